hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter AW, default 5, register-number width.
REQ-002 Parameter NSRC, default 2, source operands per instruction (1..4).
REQ-003 Parameter LOAD_LAT, default 1, load-use stall cycles (1..4).
REQ-004 Parameter EXC_FLUSH, default 2, cycles the flushes are held after an exception (1..8).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-high (1 = reset).
REQ-007 id_src  input  NSRC*AW  source register numbers of the ID instruction; operand k occupies bits [k*AW +: AW].
REQ-008 id_src_used  input  NSRC  per-operand valid for id_src.
REQ-009 ex_src  input  NSRC*AW  source register numbers of the EX instruction.
REQ-010 ex_src_used  input  NSRC  per-operand valid for ex_src.
REQ-011 ex_rd, ex_regwrite, ex_memread  input  AW,1,1  EX destination register, write enable, and load flag.
REQ-012 mem_rd, mem_regwrite  input  AW,1  MEM destination register and write enable.
REQ-013 wb_rd, wb_regwrite  input  AW,1  WB destination register and write enable.
REQ-014 branch_taken  input  1  taken branch resolved in EX.
REQ-015 exception  input  1  exception raised in EX (single-cycle pulse).
REQ-016 fwd_sel  output  2*NSRC  per EX operand: 00 register file, 01 MEM result, 10 WB data.
REQ-017 id_bypass  output  NSRC  per ID operand: take WB write data (register-file write-through).
REQ-018 stall_if, stall_id, bubble_ex  output  1,1,1  hold PC, hold IF/ID, insert nop into ID/EX.
REQ-019 flush_if_id, flush_id_ex, flush_ex_mem  output  1,1,1  clear the named pipeline register.
REQ-020 pc_sel  output  2  00 PC+4, 01 branch target, 10 exception vector.
REQ-021 exc_busy  output  1  exception flush sequence in progress.

Function
REQ-022 A register number of 0 never matches a producer and never causes forwarding, bypass, or a stall.
REQ-023 fwd_sel[k]: 01 if ex_src_used[k] and mem_regwrite and mem_rd==ex_src[k]; otherwise 10 if the same check holds for WB; otherwise 00. MEM takes priority over WB. The output is combinational.
REQ-024 id_bypass[k] = id_src_used[k] and wb_regwrite and wb_rd==id_src[k], combinational.
REQ-025 The FSM has states RUN, LSTALL, and EXC, plus a 3-bit down-counter cnt.
REQ-026 In RUN, a load-use condition exists when ex_memread, ex_regwrite, ex_rd!=0, and any used id_src equals ex_rd. On load-use, the block asserts stall_if, stall_id, and bubble_ex in that cycle; if LOAD_LAT>1 it moves to LSTALL with cnt=LOAD_LAT-2.
REQ-027 In LSTALL, the block asserts stall_if, stall_id, and bubble_ex. New load-use checks are not evaluated in this state. It returns to RUN when cnt==0, otherwise it decrements cnt. Total stall length equals LOAD_LAT cycles.
REQ-028 branch_taken in RUN or LSTALL produces, in the same cycle: pc_sel=01 and flush_if_id=1; stall_if, stall_id, and bubble_ex forced to 0; the next state is RUN.
REQ-029 exception in RUN or LSTALL produces, in the same cycle: pc_sel=10 and flush_if_id, flush_id_ex, flush_ex_mem all 1; stall and bubble outputs 0; the branch is ignored. If EXC_FLUSH>1 the next state is EXC with cnt=EXC_FLUSH-2; otherwise RUN.
REQ-030 In EXC, the block holds all three flushes at 1, exc_busy=1, pc_sel=00, and stalls at 0. branch_taken and exception are ignored, so they neither restart nor extend the sequence. It returns to RUN when cnt==0, otherwise it decrements cnt.
REQ-031 exc_busy is 1 only in EXC state. Priority is exception > branch_taken > load-use.
REQ-032 Outside the cases above, stall, bubble, and flush outputs are 0 and pc_sel=00.

Reset
REQ-033 While rst_n=1 at a rising edge, the next state is RUN and cnt=0.
REQ-034 During any cycle with rst_n=1, all outputs are driven to 0, including fwd_sel=0 and pc_sel=00. Reset mid-LSTALL or mid-EXC aborts the sequence.
REQ-035 Reset has priority over every input.

Verification
REQ-036 ex_memread=1, ex_regwrite=1, ex_rd=8, id_src0=8 used, LOAD_LAT=3 -> stall_if, stall_id, and bubble_ex high for exactly 3 cycles, then 0.
REQ-037 ex_src0=5 used, mem_rd=5, mem_regwrite=1, wb_rd=5, wb_regwrite=1 -> fwd_sel[1:0]=01; with mem_regwrite=0 -> 10; with ex_src0=0 -> 00.
REQ-038 Load-use on reg 3 together with branch_taken=1 in the same cycle -> pc_sel=01, flush_if_id=1, stall_if=0, and RUN on the next cycle.
REQ-039 exception pulse with EXC_FLUSH=3 -> pc_sel=10 in cycle 0; all three flushes high for cycles 0-2; exc_busy high for cycles 1-2; a second exception in cycle 1 does not extend the sequence.
REQ-040 rst_n=1 asserted in the second LSTALL cycle (LOAD_LAT=4) -> all outputs 0 that cycle; RUN with cnt=0 next cycle; no residual stall after release.
REQ-041 id_src1=12 used, wb_rd=12, wb_regwrite=1 -> id_bypass=2'b10; wb_rd=0 -> 2'b00.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX-operand forwarding selects, ID write-through bypass,
// load-use stalls, and branch/exception redirect with a timed flush sequence.
module hazard_unit #(
   parameter int AW        = 5,
   parameter int NSRC      = 2,
   parameter int LOAD_LAT  = 1,
   parameter int EXC_FLUSH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSRC*AW-1:0]   id_src,
   input  logic [NSRC-1:0]      id_src_used,
   input  logic [NSRC*AW-1:0]   ex_src,
   input  logic [NSRC-1:0]      ex_src_used,
   input  logic [AW-1:0]        ex_rd,
   input  logic                 ex_regwrite,
   input  logic                 ex_memread,
   input  logic [AW-1:0]        mem_rd,
   input  logic                 mem_regwrite,
   input  logic [AW-1:0]        wb_rd,
   input  logic                 wb_regwrite,
   input  logic                 branch_taken,
   input  logic                 exception,
   output logic [2*NSRC-1:0]    fwd_sel,
   output logic [NSRC-1:0]      id_bypass,
   output logic                 stall_if,
   output logic                 stall_id,
   output logic                 bubble_ex,
   output logic                 flush_if_id,
   output logic                 flush_id_ex,
   output logic                 flush_ex_mem,
   output logic [1:0]           pc_sel,
   output logic                 exc_busy
);

   typedef enum logic [1:0] {RUN, LSTALL, EXC} state_t;

   // The cycle that detects the event counts as the first one, so the counters load N-2.
   localparam logic [2:0] LSTALL_CNT = 3'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);
   localparam logic [2:0] EXC_CNT    = 3'(EXC_FLUSH > 1 ? EXC_FLUSH - 2 : 0);

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       load_use;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      load_use = 1'b0;
      if (ex_memread && ex_regwrite && ex_rd != '0) begin
         for (int k = 0; k < NSRC; k++) begin
            if (id_src_used[k] && id_src[k*AW +: AW] == ex_rd) load_use = 1'b1;
         end
      end
   end

   // Register 0 is hardwired, so a zero source never matches a producer.
   always_comb begin
      fwd_sel   = '0;
      id_bypass = '0;
      if (!rst_n) begin
         for (int k = 0; k < NSRC; k++) begin
            if (ex_src_used[k] && ex_src[k*AW +: AW] != '0) begin
               if (mem_regwrite && mem_rd == ex_src[k*AW +: AW])
                  fwd_sel[2*k +: 2] = 2'b01;
               else if (wb_regwrite && wb_rd == ex_src[k*AW +: AW])
                  fwd_sel[2*k +: 2] = 2'b10;
            end
            if (id_src_used[k] && id_src[k*AW +: AW] != '0 &&
                wb_regwrite && wb_rd == id_src[k*AW +: AW])
               id_bypass[k] = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      stall_if     = 1'b0;
      stall_id     = 1'b0;
      bubble_ex    = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      pc_sel       = 2'b00;
      exc_busy     = 1'b0;
      case (state)
         RUN, LSTALL: begin
            if (exception) begin
               pc_sel       = 2'b10;
               flush_if_id  = 1'b1;
               flush_id_ex  = 1'b1;
               flush_ex_mem = 1'b1;
               state_nxt    = (EXC_FLUSH > 1) ? EXC : RUN;
               cnt_nxt      = EXC_CNT;
            end else if (branch_taken) begin
               pc_sel      = 2'b01;
               flush_if_id = 1'b1;
               state_nxt   = RUN;
               cnt_nxt     = '0;
            end else if (state == LSTALL) begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
               if (cnt == '0) state_nxt = RUN;
               else           cnt_nxt   = cnt - 3'd1;
            end else if (load_use) begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_nxt = LSTALL;
                  cnt_nxt   = LSTALL_CNT;
               end
            end
         end
         EXC: begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            exc_busy     = 1'b1;
            if (cnt == '0) state_nxt = RUN;
            else           cnt_nxt   = cnt - 3'd1;
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase
      if (rst_n) begin
         state_nxt    = RUN;
         cnt_nxt      = '0;
         stall_if     = 1'b0;
         stall_id     = 1'b0;
         bubble_ex    = 1'b0;
         flush_if_id  = 1'b0;
         flush_id_ex  = 1'b0;
         flush_ex_mem = 1'b0;
         pc_sel       = 2'b00;
         exc_busy     = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: two instances with different latencies
// driven by shared inputs and compared against a cycle-level behavioural model.
module tb_hazard_unit;

   localparam int AW   = 5;
   localparam int NSRC = 2;
   localparam int LL0  = 3;
   localparam int EF0  = 3;
   localparam int LL1  = 4;
   localparam int EF1  = 1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NSRC*AW-1:0]  id_src, ex_src;
   logic [NSRC-1:0]     id_src_used, ex_src_used;
   logic [AW-1:0]       ex_rd, mem_rd, wb_rd;
   logic                ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
   logic                branch_taken, exception;

   logic [2*NSRC-1:0]   fwd_sel0, fwd_sel1;
   logic [NSRC-1:0]     id_bypass0, id_bypass1;
   logic                stall_if0, stall_id0, bubble_ex0, flush_if_id0, flush_id_ex0, flush_ex_mem0, exc_busy0;
   logic                stall_if1, stall_id1, bubble_ex1, flush_if_id1, flush_id_ex1, flush_ex_mem1, exc_busy1;
   logic [1:0]          pc_sel0, pc_sel1;

   // Packed view: [14:11] fwd_sel, [10:9] id_bypass, [8:6] stalls, [5:3] flushes, [2:1] pc_sel, [0] exc_busy.
   logic [14:0] obs  [2];
   logic [14:0] expv [2];
   int lrem [2];
   int erem [2];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_unit #(.AW(AW), .NSRC(NSRC), .LOAD_LAT(LL0), .EXC_FLUSH(EF0)) dut0 (
      .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
      .ex_src(ex_src), .ex_src_used(ex_src_used), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
      .wb_regwrite(wb_regwrite), .branch_taken(branch_taken), .exception(exception),
      .fwd_sel(fwd_sel0), .id_bypass(id_bypass0), .stall_if(stall_if0), .stall_id(stall_id0),
      .bubble_ex(bubble_ex0), .flush_if_id(flush_if_id0), .flush_id_ex(flush_id_ex0),
      .flush_ex_mem(flush_ex_mem0), .pc_sel(pc_sel0), .exc_busy(exc_busy0));

   hazard_unit #(.AW(AW), .NSRC(NSRC), .LOAD_LAT(LL1), .EXC_FLUSH(EF1)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
      .ex_src(ex_src), .ex_src_used(ex_src_used), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
      .wb_regwrite(wb_regwrite), .branch_taken(branch_taken), .exception(exception),
      .fwd_sel(fwd_sel1), .id_bypass(id_bypass1), .stall_if(stall_if1), .stall_id(stall_id1),
      .bubble_ex(bubble_ex1), .flush_if_id(flush_if_id1), .flush_id_ex(flush_id_ex1),
      .flush_ex_mem(flush_ex_mem1), .pc_sel(pc_sel1), .exc_busy(exc_busy1));

   assign obs[0] = {fwd_sel0, id_bypass0, stall_if0, stall_id0, bubble_ex0,
                    flush_if_id0, flush_id_ex0, flush_ex_mem0, pc_sel0, exc_busy0};
   assign obs[1] = {fwd_sel1, id_bypass1, stall_if1, stall_id1, bubble_ex1,
                    flush_if_id1, flush_id_ex1, flush_ex_mem1, pc_sel1, exc_busy1};

   // Reference: remaining stall/flush cycles owed, consumed once per clock.
   task automatic model_step();
      logic [3:0] fwd;
      logic [1:0] byp;
      logic       lu;
      logic [8:0] ctl;
      logic [AW-1:0] s;
      fwd = '0;
      byp = '0;
      lu  = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         s = ex_src[k*AW +: AW];
         if (ex_src_used[k] && s != 0 && mem_regwrite && mem_rd == s)     fwd[2*k +: 2] = 2'd1;
         else if (ex_src_used[k] && s != 0 && wb_regwrite && wb_rd == s)  fwd[2*k +: 2] = 2'd2;
         s = id_src[k*AW +: AW];
         if (id_src_used[k] && s != 0 && wb_regwrite && wb_rd == s) byp[k] = 1'b1;
         if (id_src_used[k] && s == ex_rd) lu = 1'b1;
      end
      lu = lu && ex_memread && ex_regwrite && ex_rd != 0;
      for (int i = 0; i < 2; i++) begin
         int ll;
         int ef;
         ll  = (i == 0) ? LL0 : LL1;
         ef  = (i == 0) ? EF0 : EF1;
         ctl = '0;
         if (rst_n) begin
            lrem[i] = 0;
            erem[i] = 0;
         end else if (erem[i] > 0) begin
            ctl = 9'b000_111_00_1;
            erem[i]--;
         end else if (exception) begin
            ctl = 9'b000_111_10_0;
            erem[i] = ef - 1;
            lrem[i] = 0;
         end else if (branch_taken) begin
            ctl = 9'b000_100_01_0;
            lrem[i] = 0;
         end else if (lrem[i] > 0) begin
            ctl = 9'b111_000_00_0;
            lrem[i]--;
         end else if (lu) begin
            ctl = 9'b111_000_00_0;
            lrem[i] = ll - 1;
         end
         expv[i] = rst_n ? 15'd0 : {fwd, byp, ctl};
      end
   endtask

   task automatic settle();
      #1;
      model_step();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rst_n = 1'b0; id_src = '0; id_src_used = '0; ex_src = '0; ex_src_used = '0;
      ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_rd = '0; mem_regwrite = 1'b0;
      wb_rd = '0; wb_regwrite = 1'b0; branch_taken = 1'b0; exception = 1'b0;
   endtask

   task automatic randomize_inputs();
      id_src       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_src       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_src_used  = 2'($urandom);
      ex_src_used  = 2'($urandom);
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      wb_rd        = 5'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom);
      ex_memread   = 1'($urandom);
      mem_regwrite = 1'($urandom);
      wb_regwrite  = 1'($urandom);
      branch_taken = ($urandom_range(0, 9) == 0);
      exception    = ($urandom_range(0, 19) == 0);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         randomize_inputs();
         exception = (c == 1);
         rst_n = 1'b1;
         settle();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 15'd0) begin
               failures++;
               $display("[TB] FAIL reset inst%0d obs=%h exp=%h", i, obs[i], 15'd0);
            end
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      logic [2:0] want;
      clear_inputs();
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8;
      id_src[4:0] = 5'd8; id_src_used = 2'b01;
      for (int c = 0; c < 5; c++) begin
         settle();
         want = (c < LL0) ? 3'b111 : 3'b000;
         checks++;
         if (obs[0][8:6] !== want) begin
            failures++;
            $display("[TB] FAIL load_use_c%0d stalls=%b exp=%b", c, obs[0][8:6], want);
         end
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== expv[i]) begin
               failures++;
               $display("[TB] FAIL load_use_model inst%0d obs=%h exp=%h", i, obs[i], expv[i]);
            end
         end
         tick();
         ex_memread = 1'b0;
      end
   endtask

   task automatic test_forwarding();
      logic [1:0] want_fwd [3];
      logic [1:0] want_byp [2];
      want_fwd[0] = 2'b01; want_fwd[1] = 2'b10; want_fwd[2] = 2'b00;
      want_byp[0] = 2'b10; want_byp[1] = 2'b00;
      clear_inputs();
      ex_src[4:0] = 5'd5; ex_src_used = 2'b01;
      mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
      for (int p = 0; p < 3; p++) begin
         if (p == 1) mem_regwrite = 1'b0;
         if (p == 2) ex_src[4:0] = 5'd0;
         settle();
         checks++;
         if (obs[0][12:11] !== want_fwd[p]) begin
            failures++;
            $display("[TB] FAIL fwd_p%0d fwd_sel=%b exp=%b", p, obs[0][12:11], want_fwd[p]);
         end
         tick();
      end
      clear_inputs();
      id_src[9:5] = 5'd12; id_src_used = 2'b10; wb_rd = 5'd12; wb_regwrite = 1'b1;
      for (int p = 0; p < 2; p++) begin
         if (p == 1) wb_rd = 5'd0;
         settle();
         checks++;
         if (obs[1][10:9] !== want_byp[p]) begin
            failures++;
            $display("[TB] FAIL bypass_p%0d id_bypass=%b exp=%b", p, obs[1][10:9], want_byp[p]);
         end
         tick();
      end
   endtask

   task automatic test_branch();
      clear_inputs();
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3;
      id_src[4:0] = 5'd3; id_src_used = 2'b01; branch_taken = 1'b1;
      settle();
      checks++;
      if (obs[0][8:0] !== 9'b000_100_01_0) begin
         failures++;
         $display("[TB] FAIL branch_ctl obs=%b exp=%b", obs[0][8:0], 9'b000_100_01_0);
      end
      tick();
      clear_inputs();
      settle();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs[i][8:0] !== 9'd0) begin
            failures++;
            $display("[TB] FAIL branch_after inst%0d obs=%b exp=%b", i, obs[i][8:0], 9'd0);
         end
      end
      tick();
   endtask

   task automatic test_exception();
      logic [8:0] want;
      clear_inputs();
      for (int c = 0; c < 4; c++) begin
         exception = (c < 2);
         settle();
         want = (c == 0) ? 9'b000_111_10_0 : (c < EF0) ? 9'b000_111_00_1 : 9'd0;
         checks++;
         if (obs[0][8:0] !== want) begin
            failures++;
            $display("[TB] FAIL exception_c%0d obs=%b exp=%b", c, obs[0][8:0], want);
         end
         checks++;
         if (obs[1] !== expv[1]) begin
            failures++;
            $display("[TB] FAIL exception_model inst1 c%0d obs=%h exp=%h", c, obs[1], expv[1]);
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_lstall();
      logic [2:0] want;
      clear_inputs();
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd9;
      id_src[9:5] = 5'd9; id_src_used = 2'b10;
      for (int c = 0; c < 6; c++) begin
         rst_n = (c == 2);
         settle();
         want = (c < 2) ? 3'b111 : 3'b000;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i][8:6] !== want || (c == 2 && obs[i] !== 15'd0)) begin
               failures++;
               $display("[TB] FAIL reset_mid_lstall inst%0d c%0d obs=%h exp_stalls=%b", i, c, obs[i], want);
            end
         end
         tick();
         ex_memread = 1'b0;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         randomize_inputs();
         rst_n = ($urandom_range(0, 49) == 0);
         settle();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== expv[i]) begin
               failures++;
               $display("[TB] FAIL random inst%0d c%0d obs=%h exp=%h", i, c, obs[i], expv[i]);
            end
         end
         tick();
      end
   endtask

   initial begin
      clear_inputs();
      lrem[0] = 0; lrem[1] = 0; erem[0] = 0; erem[1] = 0;
      test_reset();
      test_load_use();
      test_forwarding();
      test_branch();
      test_exception();
      test_reset_mid_lstall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
